// File: rtl/ahb_sram.sv
// ahb_sram: AHB-Lite slave over a byte-writable single-port SRAM with wait states and ERROR response.
// Define AHB_SRAM_RAW_BYPASS_EN to forward same-word write data into an immediately following read.
module ahb_sram #(
  parameter int ADDR_WIDTH  = 12,
  parameter bit READ_ONLY   = 1'b0,
  parameter int WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] haddr,
  input  logic        hwrite,
  input  logic [2:0]  hsize,
  input  logic [2:0]  hburst,
  input  logic [3:0]  hprot,
  input  logic [1:0]  htrans,
  input  logic        hmastlock,
  input  logic [31:0] hwdata,
  output logic [31:0] hrdata,
  input  logic        hsel,
  input  logic        hreadyin,
  output logic        hreadyout,
  output logic        hresp
);
  typedef enum logic [2:0] {S_IDLE, S_DATA, S_RAW, S_ERR1, S_ERR2} state_t;
  state_t                r_state, w_next;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [3:0]            r_be;
  logic                  r_write;
  logic [2:0]            r_cnt;
  logic [31:0]           r_rdata;
  logic [31:0]           r_mem [2**ADDR_WIDTH];
  logic [ADDR_WIDTH-1:0] w_waddr;
  logic [3:0]            w_be;
  logic [31:0]           w_rd, w_merge;
  logic                  w_err, w_acc, w_we, w_haz, w_stall, w_unused;
  assign w_unused  = ^{hburst, hprot, hmastlock, haddr[31:ADDR_WIDTH+2]};
  assign w_waddr   = haddr[ADDR_WIDTH+1:2];
  assign w_err     = (hsize > 3'd2) | (hsize == 3'd1 & haddr[0]) | (hsize == 3'd2 & |haddr[1:0]) | (READ_ONLY & hwrite);
  assign w_be      = hsize == 3'd0 ? 4'b0001 << haddr[1:0] : hsize == 3'd1 ? (haddr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  assign hreadyout = r_state == S_DATA ? r_cnt == 3'(WAIT_STATES) : r_state != S_RAW && r_state != S_ERR1;
  assign hresp     = r_state == S_ERR1 || r_state == S_ERR2;
  assign hrdata    = r_state == S_DATA && hreadyout && !r_write ? r_rdata : 32'h0;
  assign w_acc     = hsel & hreadyin & htrans[1] & hreadyout;
  // the write commits on its completing cycle; a reset in that cycle drops it
  assign w_we      = r_state == S_DATA & r_write & hreadyout & ~reset;
  assign w_haz     = w_acc & ~hwrite & w_we & (w_waddr == r_addr);
  assign w_rd      = r_mem[w_waddr];
`ifdef AHB_SRAM_RAW_BYPASS_EN
  assign w_stall = 1'b0;
  always_comb begin
    w_merge = w_rd;
    for (int i = 0; i < 4; i++)
      w_merge[8*i +: 8] = w_haz && r_be[i] ? hwdata[8*i +: 8] : w_rd[8*i +: 8];
  end
`else
  assign w_stall = w_haz;
  assign w_merge = w_rd;
`endif
  always_comb begin
    w_next = !hreadyout ? (r_state == S_ERR1 ? S_ERR2 : S_DATA) :
             !w_acc     ? S_IDLE :
             w_err      ? S_ERR1 :
             w_stall    ? S_RAW  : S_DATA;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 3'd0;
    end else begin
      r_state <= w_next;
      r_cnt   <= r_state == S_DATA && !hreadyout ? r_cnt + 3'd1 : 3'd0;
    end
  end
  always_ff @(posedge clk) begin
    if (w_acc) begin
      r_addr  <= w_waddr;
      r_be    <= w_be;
      r_write <= hwrite;
    end
    // the stall cycle re-reads the word after the colliding write has landed
    if (w_acc) r_rdata <= w_merge;
    else if (r_state == S_RAW) r_rdata <= r_mem[r_addr];
  end
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (w_we && r_be[i]) r_mem[r_addr][8*i +: 8] <= hwdata[8*i +: 8];
  end
endmodule

// File: doc/ahb_sram.md
# ahb_sram

AHB-Lite slave wrapping a single-port, byte-writable on-chip memory of configurable depth. It implements the address/data phase pipeline, so read data is returned in the data phase of the addressed transfer. It also supports byte, halfword and word writes, programmable wait states, and the two-cycle ERROR response. It replaces fixed-depth, read-only, always-ready memory slaves on the system bus as the general program/data memory.

## Interface
- ADDR_WIDTH, 12, word-address bits; depth = 2**ADDR_WIDTH 32-bit words; haddr[ADDR_WIDTH+1:2] selects the word, upper bits ignored (aliasing)
- READ_ONLY, 0, 1 = every write transfer gets an ERROR response and memory is unchanged
- WAIT_STATES, 0, extra data-phase cycles with hreadyout=0 on every OKAY transfer (0..7)

Ports:
- clk  in  1  single clock, all logic rising-edge
- reset  in  1  synchronous, active-high
- haddr  in  32  address
- hwrite  in  1  1 = write
- hsize  in  3  0 byte, 1 halfword, 2 word; others illegal
- hburst  in  3  ignored (each beat treated as single)
- hprot  in  4  ignored
- htrans  in  2  transfer is active when htrans[1]=1 (NONSEQ/SEQ)
- hmastlock  in  1  ignored
- hwdata  in  32  write data, sampled in data phase
- hrdata  out  32  read data
- hsel  in  1  slave select
- hreadyin  in  1  bus ready; address phase accepted only when 1
- hreadyout  out  1  slave ready
- hresp  out  1  0 OKAY, 1 ERROR

## Operation
- Accept: hsel & hreadyin & htrans[1]. On accept, register the word address, byte lane enables, hwrite, and the error flag.
- Error conditions:
  - hsize > 2
  - misaligned: halfword with haddr[0]=1, or word with haddr[1:0]≠0
  - write when READ_ONLY=1
- Byte lanes (little-endian):
  - byte: lane haddr[1:0]
  - halfword: lanes {haddr[1],0} and {haddr[1],1}
  - word: all four lanes
- Read: memory is read with the address-phase word address at accept, so data is ready at the start of the data phase.
- Write: enabled lanes of hwdata are written at the final data-phase cycle.
- Read-after-write hazard: a read accepted in the same cycle as a write data phase to the same word. Handling is set by the Configuration macro.
- States:
  - IDLE: hreadyout=1, hresp=0.
  - Accepted OKAY transfer: go to WAIT if WAIT_STATES>0, else complete in the data phase.
  - WAIT: counter counts WAIT_STATES cycles with hreadyout=0, hresp=0, then one cycle with hreadyout=1.
  - Accepted erroring transfer: ERR1 (hreadyout=0, hresp=1), then ERR2 (hreadyout=1, hresp=1), then IDLE or the next accepted transfer.
  - Erroring transfers bypass wait states and never write memory.
- hrdata = 32'h0 except in the completing (hreadyout=1) cycle of an OKAY read data phase.
- Idle/busy transfers or hsel=0: zero-wait OKAY, no side effects.

## Timing
- Reset: hreadyout=1, hresp=0, hrdata=0, state IDLE, wait counter 0. Memory contents are not cleared.
- Reset asserted mid-transfer aborts it. An uncommitted write is dropped; the next cycle is IDLE.
- Read latency: data valid in the data phase after WAIT_STATES extra cycles. With WAIT_STATES=0, back-to-back reads run one per cycle.
- Back-to-back writes run one per cycle with WAIT_STATES=0.
- No address phase is accepted while hreadyout=0, because hreadyin follows hreadyout on a single-slave bus.

## Configuration
- AHB_SRAM_RAW_BYPASS_EN defined:
  - the same-word read-after-write hazard is resolved by merging the written lanes of hwdata into the read data
  - zero added latency
- Not defined:
  - the read data phase inserts one extra hreadyout=0 cycle
  - memory is re-read after the write commits
  - the total then includes WAIT_STATES

## Test plan
- WAIT_STATES=0: word write 32'hDEADBEEF @0x10, then read @0x10 → hrdata=32'hDEADBEEF, hreadyout never low.
- Byte write 8'hA5 @0x13 over 32'h00000000, read word @0x10 → 32'hA5000000. Halfword 16'h1234 @0x12 → 32'h12340000.
- Write @0x20 immediately followed by read @0x20 → 32'h5A5A5A5A.
  - With macro: zero stall.
  - Without macro: exactly one hreadyout=0 cycle.
- Errors, each checked for ERR1 (hreadyout=0, hresp=1) then ERR2 (hreadyout=1, hresp=1), with memory unchanged on readback:
  - word access @0x02
  - hsize=3
  - write with READ_ONLY=1
- WAIT_STATES=3: read → exactly 3 hreadyout=0 cycles, then data. Reset asserted during the 2nd wait cycle → next cycle hreadyout=1, hresp=0, hrdata=0.
